// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared stream beat layout and framing state type
package stream_pkg;

  localparam int STREAM_DATA_WIDTH = 26;
  localparam int STREAM_SOP_BIT    = 25;
  localparam int STREAM_EOP_BIT    = 24;
  localparam int STREAM_RGB_WIDTH  = 24;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } frame_state_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// rtl/stream_skid_fifo.sv - small skid FIFO absorbing the in-flight beat after ready drops
module stream_skid_fifo #(
  parameter int DEPTH      = 2,
  parameter int DATA_WIDTH = 26
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic [DATA_WIDTH-1:0]        head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [$clog2(DEPTH+1)-1:0]   count_next
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  // Explicit wrap keeps non-power-of-two depths inside the array.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // Occupancy after this cycle's push/pop; the caller guarantees no overfill.
  always_comb begin
    count_next = count + CW'(push) - CW'(pop);
  end

  // Head is forced to zero when empty so stale storage never leaks out.
  always_comb begin
    head = '0;
    if (count != '0) head = mem[rd_ptr];
  end

  // Storage is not reset; only occupancy decides what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count_next;
    end
  end

endmodule

// File: rtl/stream_reg_release.sv
// rtl/stream_reg_release.sv - ready-latency-1 to ready-latency-0 stream adapter with framing check
module stream_reg_release
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH    = STREAM_DATA_WIDTH,
  parameter int DEPTH         = 2,
  parameter int SOP_BIT       = STREAM_SOP_BIT,
  parameter int EOP_BIT       = STREAM_EOP_BIT,
  parameter int CHECK_FRAMING = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid_in,
  input  logic [DATA_WIDTH-1:0]       data_in,
  output logic                        ready_out,
  output logic                        valid_out,
  output logic [DATA_WIDTH-1:0]       data_out,
  input  logic                        ready_in,
  output logic                        err_overflow,
  output logic                        err_framing,
  output logic [$clog2(DEPTH+1)-1:0]  level
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam bit CHECK_EN = (CHECK_FRAMING != 0);

  logic          ready_q;
  logic          push;
  logic          pop;
  logic          full;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  frame_state_t  frame_state;
  frame_state_t  frame_next;
  logic          frame_bad;

  stream_skid_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .wr_data    (data_in),
    .head       (data_out),
    .count      (count),
    .count_next (count_next)
  );

  // A beat is only taken if ready was offered last cycle and there is room
  // (a simultaneous pop frees the slot, so full-with-pop still accepts).
  assign full      = (count == DEPTH_C);
  assign pop       = (count != '0) & ready_in;
  assign push      = valid_in & ready_q & ~(full & ~pop);
  assign valid_out = (count != '0);
  assign level     = count;
  // Offer ready only if the beat arriving next cycle is guaranteed a slot.
  assign ready_out = rst_n & (count_next < DEPTH_C);

  // Remember what upstream saw so the next cycle's beat can be qualified.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= ready_out;
  end

  // Sticky overflow: any offered beat that is not pushed was lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                err_overflow <= 1'b0;
    else if (valid_in & ~push) err_overflow <= 1'b1;
  end

  // Framing state register, advanced only by accepted beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_state <= IDLE;
    else        frame_state <= frame_next;
  end

  // Framing next-state: a stray sop restarts the packet rather than resyncing later.
  always_comb begin
    frame_next = frame_state;
    frame_bad  = 1'b0;
    if (push) begin
      case (frame_state)
        IDLE: begin
          if (!data_in[SOP_BIT])     frame_bad  = 1'b1;
          else if (!data_in[EOP_BIT]) frame_next = IN_PKT;
        end
        IN_PKT: begin
          if (data_in[SOP_BIT]) frame_bad = 1'b1;
          if (data_in[EOP_BIT]) frame_next = IDLE;
        end
        default: frame_next = IDLE;
      endcase
    end
  end

  // Sticky framing error, held low when the checker is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    err_framing <= 1'b0;
    else if (CHECK_EN && frame_bad) err_framing <= 1'b1;
  end

endmodule

// File: tb/tb_stream_reg_release.sv
// tb/tb_stream_reg_release.sv - randomized and directed bench for stream_reg_release
module tb_stream_reg_release;

  localparam int DW    = 26;
  localparam int DEPTH = 2;
  localparam int LW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          ready_in = 1'b0;
  logic          ready_out;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic          err_overflow;
  logic          err_framing;
  logic [LW-1:0] level;

  stream_reg_release #(
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH),
    .SOP_BIT       (25),
    .EOP_BIT       (24),
    .CHECK_FRAMING (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .ready_out    (ready_out),
    .valid_out    (valid_out),
    .data_out     (data_out),
    .ready_in     (ready_in),
    .err_overflow (err_overflow),
    .err_framing  (err_framing),
    .level        (level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: a queue of stored beats plus a few flags.
  logic [DW-1:0] mq[$];
  bit m_rdy = 1'b0;
  bit m_ov = 1'b0;
  bit m_fr = 1'b0;
  bit m_inpkt = 1'b0;
  bit rdy_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_pop();
    return (mq.size() != 0) && ready_in;
  endfunction

  function automatic bit m_push();
    bit p;
    p = m_pop();
    return valid_in && m_rdy && !(mq.size() == DEPTH && !p);
  endfunction

  // Model update on the clock; async reset empties everything at once.
  always @(posedge clk or negedge rst_n) begin
    bit p, u, er, sop, eop;
    if (!rst_n) begin
      mq.delete();
      m_rdy = 1'b0; m_ov = 1'b0; m_fr = 1'b0; m_inpkt = 1'b0;
    end else begin
      p  = m_pop();
      u  = m_push();
      er = (mq.size() + int'(u) - int'(p)) < DEPTH;
      if (valid_in && !u) m_ov = 1'b1;
      if (p) void'(mq.pop_front());
      if (u) begin
        sop = data_in[25];
        eop = data_in[24];
        if ((!m_inpkt && !sop) || (m_inpkt && sop)) m_fr = 1'b1;
        m_inpkt = sop ? !eop : (m_inpkt && !eop);
        mq.push_back(data_in);
      end
      m_rdy = er;
    end
  end

  // Every cycle, compare all outputs with the model mid-cycle.
  always @(negedge clk) begin
    int n;
    bit p, u, er;
    n  = mq.size();
    p  = m_pop();
    u  = m_push();
    er = rst_n && ((n + int'(u) - int'(p)) < DEPTH);
    chk("valid_out", 32'(valid_out), 32'(n != 0));
    chk("data_out", 32'(data_out), (n != 0) ? 32'(mq[0]) : 32'd0);
    chk("level", 32'(level), 32'(n));
    chk("ready_out", 32'(ready_out), 32'(er));
    chk("err_overflow", 32'(err_overflow), 32'(m_ov));
    chk("err_framing", 32'(err_framing), 32'(m_fr));
  end

  // One cycle of stimulus, returning 1 time unit after the next rising edge.
  task automatic cyc(input bit v, input logic [DW-1:0] d, input bit r);
    valid_in = v;
    data_in  = d;
    ready_in = r;
    @(negedge clk);
    rdy_seen = ready_out;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(0, '0, 0);
    rst_n = 1'b1;
    cyc(0, '0, 1);
  endtask

  function automatic logic [DW-1:0] beat(input bit sop, input bit eop, input logic [23:0] rgb);
    return {sop, eop, rgb};
  endfunction

  initial begin
    logic [DW-1:0] b [4];
    logic [DW-1:0] d;
    bit v;

    // Reset state
    cyc(0, '0, 0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ready", 32'(ready_out), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 32'(ready_out), 32'd1);
    cyc(0, '0, 1);

    // 4-beat packet, full throughput
    for (int i = 0; i < 4; i++) begin
      d = beat(i == 0, i == 3, 24'h100000 + 24'(i));
      cyc(rdy_seen, d, 1);
      chk("pkt_data", 32'(data_out), 32'(d));
      chk("pkt_level", 32'(level), 32'd1);
    end
    cyc(0, '0, 1);
    chk("pkt_err", 32'({err_overflow, err_framing}), 32'd0);

    // Stall with one beat in flight, then an illegal beat while ready_q is low
    b[0] = beat(1, 0, 24'h200001);
    b[1] = beat(0, 0, 24'h200002);
    b[2] = beat(0, 0, 24'h200003);
    b[3] = beat(0, 1, 24'h200004);
    cyc(1, b[0], 0);
    chk("stall_ready_a", 32'(rdy_seen), 32'd1);
    cyc(1, b[1], 0);
    chk("stall_ready_b", 32'(rdy_seen), 32'd0);
    chk("stall_level", 32'(level), 32'd2);
    cyc(1, 26'h0ABCDEF, 0);
    chk("ovf_flag", 32'(err_overflow), 32'd1);
    chk("ovf_level", 32'(level), 32'd2);
    chk("drain_head0", 32'(data_out), 32'(b[0]));
    cyc(0, '0, 1);
    chk("drain_head1", 32'(data_out), 32'(b[1]));
    cyc(1, b[2], 1);
    chk("resume_head", 32'(data_out), 32'(b[2]));
    cyc(1, b[3], 1);
    chk("resume_tail", 32'(data_out), 32'(b[3]));
    cyc(0, '0, 1);
    chk("ovf_sticky", 32'(err_overflow), 32'd1);
    chk("ovf_fr_clean", 32'(err_framing), 32'd0);

    // Async reset mid-packet at level 2
    cyc(1, beat(1, 0, 24'h300001), 0);
    cyc(1, beat(0, 0, 24'h300002), 0);
    chk("pre_rst_level", 32'(level), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(valid_out), 32'd0);
    chk("arst_ready", 32'(ready_out), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_ovf", 32'(err_overflow), 32'd0);
    ready_in = 1'b1;
    valid_in = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(ready_out), 32'd1);
    rdy_seen = ready_out;

    // Single-beat packet then a normal packet: no framing error
    cyc(rdy_seen, beat(1, 1, 24'h400001), 1);
    cyc(rdy_seen, beat(1, 0, 24'h400002), 1);
    cyc(rdy_seen, beat(0, 1, 24'h400003), 1);
    cyc(0, '0, 1);
    chk("single_fr", 32'(err_framing), 32'd0);

    // Missing sop while idle
    cyc(rdy_seen, beat(0, 0, 24'h500001), 1);
    chk("nosop_fr", 32'(err_framing), 32'd1);
    chk("nosop_fwd", 32'(data_out), 32'h0500001);
    do_reset();

    // Second sop before eop: both beats forwarded
    cyc(rdy_seen, beat(1, 0, 24'h600001), 1);
    cyc(rdy_seen, beat(1, 0, 24'h600002), 1);
    chk("dupsop_fr", 32'(err_framing), 32'd1);
    chk("dupsop_fwd", 32'(data_out), 32'h2600002);
    cyc(0, '0, 1);
    do_reset();

    // Random traffic, mostly legal with occasional protocol violations
    for (int i = 0; i < 3000; i++) begin
      v = rdy_seen ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 99) == 0);
      d = beat($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 24'($urandom));
      cyc(v, d, $urandom_range(0, 9) < 7);
      if (i % 1000 == 999) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_reg_release.md
Name: stream_reg_release

Overview:
- Sink-side counterpart of our ready-latency-1 stream output stage. It accepts an Avalon-ST-style video stream whose upstream honours readyLatency = 1: a beat may arrive one cycle after ready was sampled high.
- It re-presents the stream with readyLatency = 0 (plain valid/ready) to downstream vision filters.
- A small skid FIFO absorbs the beat still in flight after ready drops.
- Also checks SOP/EOP framing and flags protocol violations with sticky error bits.

Parameters:
- DATA_WIDTH, 26: beat width, packed as {sop, eop, rgb[23:0]}.
- DEPTH, 2: skid FIFO entries; legal range 2..8. A value of 2 sustains full throughput.
- SOP_BIT, 25: bit index of start-of-packet within the beat.
- EOP_BIT, 24: bit index of end-of-packet within the beat.
- CHECK_FRAMING, 1: 1 enables the framing checker; 0 holds err_framing at 0.

Ports:
- clk, in, 1: single clock.
- rst_n, in, 1: asynchronous active-low reset.
- valid_in, in, 1: upstream beat valid; legal only in the cycle after ready_out was high.
- data_in, in, DATA_WIDTH: upstream beat.
- ready_out, out, 1: to upstream; permits a beat in the next cycle.
- valid_out, out, 1: downstream beat valid (readyLatency 0).
- data_out, out, DATA_WIDTH: downstream beat (FIFO head).
- ready_in, in, 1: downstream ready; a transfer happens when valid_out & ready_in.
- err_overflow, out, 1: sticky; a beat arrived when it was not permitted.
- err_framing, out, 1: sticky; SOP/EOP sequence violation.
- level, out, $clog2(DEPTH+1): current FIFO occupancy.

Behaviour:
- Reset (asynchronous, active-low):
  - While rst_n = 0: count = 0, rd/wr pointers = 0, ready_q = 0, frame state = IDLE, both error flags = 0.
  - Outputs during reset: valid_out = 0, data_out = 0, ready_out = 0, level = 0.
  - Storage contents need not reset; data_out is forced 0 whenever count = 0.
  - Assertion of rst_n mid-packet discards all stored beats and any in-flight beat.
- ready_q (internal) is a register holding last cycle's ready_out.
- Push and pop:
  - push = valid_in & ready_q.
  - pop = valid_out & ready_in.
  - count_next = count + push - pop.
- ready_out = rst_n & (count_next < DEPTH), a combinational function of registered count, push and pop. This guarantees space for the beat arriving next cycle even if downstream stalls.
- Simultaneous push and pop: count unchanged and both pointers advance. When full with push=1 and pop=1, data is still accepted. This case cannot arise by construction, but is defined this way.
- Pointers wrap modulo DEPTH. For DEPTH not a power of two, explicit wrap to 0 at DEPTH-1.
- valid_out = (count != 0). data_out = mem[rd_ptr].
- Latency: a beat pushed in cycle t is visible on valid_out/data_out at cycle t+1.
- Data may change only after a pop. valid_out never drops without a pop.
- Throughput: with DEPTH = 2 and ready_in held high, one beat per cycle, steady-state count = 1.
- Overflow handling:
  - valid_in & ~ready_q: beat dropped (no push) and err_overflow set.
  - Also set if a push would exceed DEPTH; that beat is dropped.
  - Cleared only by reset.
- Framing FSM (on pushed beats only):
  - State IDLE:
    - sop=1, eop=0 -> IN_PKT.
    - sop=1, eop=1 -> stays IDLE (single-beat packet).
    - sop=0 -> err_framing, stays IDLE.
  - State IN_PKT:
    - eop=1, sop=0 -> IDLE.
    - sop=1 -> err_framing; treated as new packet start (eop=1 -> IDLE, else IN_PKT).
    - Otherwise stays in IN_PKT.
  - Beats are forwarded unchanged regardless of framing errors.
- level = count.

Decomposition:
- Shared package stream_pkg holds:
  - STREAM_DATA_WIDTH = 26, STREAM_SOP_BIT = 25, STREAM_EOP_BIT = 24, STREAM_RGB_WIDTH = 24;
  - the frame_state_t enum {IDLE, IN_PKT}.
- One sub-module: stream_skid_fifo.
  - Parameterised DEPTH/DATA_WIDTH; holds mem, pointers, count.
  - Exposes push, pop, head, count, count_next.
- The top level holds ready_q, the overflow logic and the framing FSM.

Test Plan:
- Reset, then ready_in = 1; send a 4-beat packet (sop on beat 0, eop on beat 3), one beat per cycle after ready_out -> data_out matches each beat exactly one cycle after arrival; level stays ≤1; errors stay 0.
- Stall: hold ready_in = 0 while streaming -> ready_out falls when count_next = 2; the single in-flight beat is accepted; level peaks at 2; no drop. Release ready_in -> 2 beats drain in order, then streaming resumes without gaps.
- Drive valid_in with data 0x0ABCDEF in a cycle where ready_q = 0 -> beat absent from the output; err_overflow = 1 and stays 1 until rst_n pulses low.
- Framing: beat without sop while IDLE -> err_framing = 1. Separately, a second sop before eop -> err_framing = 1; both beats are still forwarded.
- Single-beat packet (sop=1, eop=1), then a normal packet -> no err_framing.
- Assert rst_n low asynchronously mid-packet with level = 2 -> valid_out, ready_out and level go 0 immediately. After release, ready_out = 1 on the first clock and the FSM is IDLE.
